wide_add_sequencer: RTL

- Multi-cycle add/subtract controller that time-multiplexes one internal thirty_two_bit_cla instance over operands of WORDS x 32 bits.
- Processes one 32-bit word per cycle, LSW first, and chains the carry through a register between words.
- Serves as the wide-integer arithmetic unit beside the ALU, for 64-bit and wider add/sub without duplicating adder hardware.
- Uses a start/ready/done handshake and reports carry, signed overflow and zero flags.

---
 rtl/wide_add_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-cycle wide add/subtract. One 32-bit carry-lookahead adder is reused
//   across WORDS words, LSW first, with the carry chained through a register.
//   The operation takes WORDS RUN cycles, then a one-cycle DONE that pulses
//   o_done.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      request; accepted only while o_ready=1
//   i_op_sub     0 = a+b, 1 = a-b (sampled with i_start)
//   i_a, i_b     W-bit operands (sampled with i_start), W = 32*WORDS
//   o_ready      high in IDLE
//   o_busy       high in RUN and DONE
//   o_done       one-cycle pulse; result/flags valid from this cycle on
//   o_result     W-bit sum/difference (modulo 2^W)
//   o_carry_out  carry out of MSW (subtract: 1 = no borrow)
//   o_overflow   signed overflow of the full W-bit operation
//   o_zero       result == 0

// 32-bit adder: 4-bit groups with ripple inside a group and group
// generate/propagate lookahead to skip carries across groups.
module thirty_two_bit_cla (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_p, w_g;
    logic [32:0] w_c;

    always_comb begin
        w_p = i_a ^ i_b;
        w_g = i_a & i_b;
        w_c = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
            end
            // Group carry computed directly from the group carry-in.
            w_c[4*k+4] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | ((&w_p[4*k +: 4]) & w_c[4*k]);
        end
        o_sum  = w_p ^ w_c[31:0];
        o_cout = w_c[32];
    end
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_op_sub,
    input  logic [32*WORDS-1:0]   i_a,
    input  logic [32*WORDS-1:0]   i_b,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [32*WORDS-1:0]   o_result,
    output logic                  o_carry_out,
    output logic                  o_overflow,
    output logic                  o_zero
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [WORDS-1:0][31:0]  r_a, r_b, r_res, w_res_next;
    logic                    r_sub, r_carry, r_cout, r_ovf, r_zero;
    logic [IW-1:0]           r_idx;
    logic [31:0]             w_sum;
    logic                    w_cout, w_last, w_ovf;

    thirty_two_bit_cla u_cla (
        .i_a   (r_a[r_idx]),
        .i_b   (r_b[r_idx] ^ {32{r_sub}}),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    assign w_last = (r_idx == IW'(WORDS - 1));

    // Full result as it will look after this edge, so the zero flag
    // includes the word being written on the final RUN cycle.
    always_comb begin
        w_res_next        = r_res;
        w_res_next[r_idx] = w_sum;
    end

    // Sign of B after the subtract inversion is what matters for overflow.
    assign w_ovf = (r_a[WORDS-1][31] == (r_b[WORDS-1][31] ^ r_sub)) &&
                   (w_sum[31] != r_a[WORDS-1][31]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) w_next = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            // Result and flags are left alone; they hold until overwritten.
            r_a     <= i_a;
            r_b     <= i_b;
            r_sub   <= i_op_sub;
            r_carry <= i_op_sub;   // +1 of the two's-complement negate
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_res   <= w_res_next;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign o_result    = r_res;
    assign o_carry_out = r_cout;
    assign o_overflow  = r_ovf;
    assign o_zero      = r_zero;
endmodule
